// File: rtl/spike_event_encoder.sv
// Spike event encoder: snapshots a neuron spike vector on time_step and emits one address word per set bit through a FWFT FIFO.
// Optional feature: define SPIKE_TIMESTAMP_EN to stamp each event with the time-step counter in out_word[31:16].
module spike_event_encoder #(
    parameter int         NUM_NEURONS = 32,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [9:0] BASE_ADDR   = 10'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   time_step,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_word,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            spike_count
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef SPIKE_TIMESTAMP_EN
    localparam int ENTRY_W = 26;
`else
    localparam int ENTRY_W = 10;
`endif

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] snap_q, snap_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            spike_count_q, spike_count_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
`ifdef SPIKE_TIMESTAMP_EN
    logic [15:0]            ts_q, ts_d;
    logic [15:0]            snap_ts_q, snap_ts_d;
`endif

    logic [IDX_W-1:0]       sel_idx;
    logic [9:0]             sel_addr;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     rd_entry;
    logic                   push;
    logic                   pop;

    // Priority encoder: the lowest-index pending spike wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (snap_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_addr = BASE_ADDR + 10'(sel_idx);
`ifdef SPIKE_TIMESTAMP_EN
    assign push_entry = {snap_ts_q, sel_addr};
`else
    assign push_entry = sel_addr;
`endif

    assign push      = (state_q == SCAN) && !full_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign rd_entry  = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        spike_count_d = spike_count_q;
`ifdef SPIKE_TIMESTAMP_EN
        ts_d          = time_step ? ts_q + 16'd1 : ts_q;
        snap_ts_d     = snap_ts_q;
`endif
        case (state_q)
            IDLE: begin
                if (time_step && (spikes_in != '0)) begin
                    snap_d  = spikes_in;
                    state_d = SCAN;
`ifdef SPIKE_TIMESTAMP_EN
                    snap_ts_d = ts_q;
`endif
                end
            end
            SCAN: begin
                if (time_step) begin
                    overflow_d = 1'b1;
                end
                if (push) begin
                    // Clearing the lowest set bit matches the index chosen above.
                    snap_d = snap_q & (snap_q - NUM_NEURONS'(1));
                    if ((snap_q & (snap_q - NUM_NEURONS'(1))) == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (spike_count_q != 16'hFFFF) begin
                spike_count_d = spike_count_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            snap_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            spike_count_q <= '0;
`ifdef SPIKE_TIMESTAMP_EN
            ts_q          <= '0;
            snap_ts_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            spike_count_q <= spike_count_d;
`ifdef SPIKE_TIMESTAMP_EN
            ts_q          <= ts_d;
            snap_ts_q     <= snap_ts_d;
`endif
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        out_word = '0;
        if (out_valid) begin
`ifdef SPIKE_TIMESTAMP_EN
            out_word = {rd_entry[25:10], 6'b0, rd_entry[9:0]};
`else
            out_word = {22'b0, rd_entry};
`endif
        end
    end

    assign busy        = (state_q == SCAN);
    assign overflow    = overflow_q;
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Scoreboard bench for spike_event_encoder: directed time steps, expected event words queued, monitors pop and compare.
module tb_spike_event_encoder;

    logic        clk;
    logic        rst;
    logic        ts0, ts1;
    logic [31:0] sp0, sp1;
    logic        rdy0, rdy1;
    logic        v0, v1;
    logic [31:0] w0, w1;
    logic        busy0, busy1;
    logic        ovf0, ovf1;
    logic [15:0] cnt0, cnt1;

    int          checks = 0;
    int          errors = 0;
    int          ts0m   = 0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    spike_event_encoder #(.NUM_NEURONS(32), .FIFO_DEPTH(16), .BASE_ADDR(10'd0)) dut0 (
        .clk(clk), .rst(rst), .time_step(ts0), .spikes_in(sp0),
        .out_valid(v0), .out_ready(rdy0), .out_word(w0),
        .busy(busy0), .overflow(ovf0), .spike_count(cnt0)
    );

    spike_event_encoder #(.NUM_NEURONS(32), .FIFO_DEPTH(16), .BASE_ADDR(10'd1000)) dut1 (
        .clk(clk), .rst(rst), .time_step(ts1), .spikes_in(sp1),
        .out_valid(v1), .out_ready(rdy1), .out_word(w1),
        .busy(busy1), .overflow(ovf1), .spike_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [31:0] ev(input int stamp, input int addr);
`ifdef SPIKE_TIMESTAMP_EN
        return {stamp[15:0], 6'b0, addr[9:0]};
`else
        return {16'b0, 6'b0, addr[9:0]};
`endif
    endfunction

    // Monitors: every valid cycle is compared against the queue head; the head is retired on a handshake.
    always @(negedge clk) begin
        if (!rst && v0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_extra_event: got %h expected none", w0);
            end else begin
                check("dut0_word", w0, exp0_q[0]);
                if (rdy0) void'(exp0_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && v1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_extra_event: got %h expected none", w1);
            end else begin
                check("dut1_word", w1, exp1_q[0]);
                if (rdy1) void'(exp1_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input logic [31:0] v);
        ts0 = 1'b1;
        sp0 = v;
        next_cycle();
        ts0 = 1'b0;
        sp0 = '0;
        ts0m++;
    endtask

    task automatic wait_drain0(input string name);
        for (int k = 0; k < 200; k++) begin
            if (exp0_q.size() == 0) break;
            next_cycle();
        end
        check(name, exp0_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp0_q.delete();
        ts0m = 0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst = 1'b1;
        ts0 = 1'b0; ts1 = 1'b0;
        sp0 = '0;   sp1 = '0;
        rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", v0, 0);
        check("rst_out_word", w0, 0);
        check("rst_busy", busy0, 0);
        check("rst_overflow", ovf0, 0);
        check("rst_spike_count", cnt0, 0);
        next_cycle();

        // Base address wrap: bit 0 -> 1000, bit 30 -> 1030 mod 1024 = 6.
        exp1_q.push_back(ev(0, 1000));
        exp1_q.push_back(ev(0, 6));
        ts1 = 1'b1;
        sp1 = 32'h4000_0001;
        next_cycle();
        ts1 = 1'b0;
        sp1 = '0;
        for (int k = 0; k < 50; k++) begin
            if (exp1_q.size() == 0) break;
            next_cycle();
        end
        check("dut1_drain", exp1_q.size(), 0);

        // Two spikes: latency t+2, busy for exactly two cycles.
        st = ts0m;
        exp0_q.push_back(ev(st, 0));
        exp0_q.push_back(ev(st, 2));
        pulse0(32'h0000_0005);
        @(negedge clk);
        check("t1_busy", busy0, 1);
        check("t1_out_valid", v0, 0);
        next_cycle();
        @(negedge clk);
        check("t2_out_valid", v0, 1);
        check("t2_busy", busy0, 1);
        next_cycle();
        @(negedge clk);
        check("t3_busy", busy0, 0);
        wait_drain0("drain_two_spikes");
        check("count_after_two", cnt0, 2);

        // All 32 spikes with the consumer stalled: FIFO fills, scan stalls, nothing dropped.
        rdy0 = 1'b0;
        st = ts0m;
        for (int i = 0; i < 32; i++) exp0_q.push_back(ev(st, i));
        pulse0(32'hFFFF_FFFF);
        repeat (25) next_cycle();
        @(negedge clk);
        check("stall_busy", busy0, 1);
        check("stall_count", cnt0, 18);
        check("stall_out_valid", v0, 1);
        next_cycle();
        rdy0 = 1'b1;
        wait_drain0("drain_all_32");
        check("all32_overflow", ovf0, 0);
        check("all32_count", cnt0, 34);
        check("all32_busy", busy0, 0);

        // A second time step during the scan is dropped and flagged.
        st = ts0m;
        for (int i = 0; i < 8; i++) exp0_q.push_back(ev(st, i));
        pulse0(32'h0000_00FF);
        next_cycle();
        next_cycle();
        pulse0(32'h0000_00FF);
        wait_drain0("drain_ff");
        repeat (5) next_cycle();
        @(negedge clk);
        check("ff_overflow", ovf0, 1);
        check("ff_count", cnt0, 42);
        check("ff_out_valid", v0, 0);
        next_cycle();

        // Timestamps: an empty step still advances the counter.
        do_reset();
        @(negedge clk);
        check("rst2_overflow", ovf0, 0);
        check("rst2_count", cnt0, 0);
        next_cycle();
        pulse0(32'h0000_0000);
        @(negedge clk);
        check("zero_vec_busy", busy0, 0);
        next_cycle();
        st = ts0m;
        exp0_q.push_back(ev(st, 3));
        pulse0(32'h0000_0008);
        wait_drain0("drain_ts1");
        st = ts0m;
        exp0_q.push_back(ev(st, 3));
        pulse0(32'h0000_0008);
        wait_drain0("drain_ts2");
        check("ts_count", cnt0, 2);

        // Reset mid-scan abandons the remaining events.
        rdy0 = 1'b0;
        st = ts0m;
        for (int i = 0; i < 4; i++) exp0_q.push_back(ev(st, i));
        pulse0(32'h0000_000F);
        next_cycle();
        do_reset();
        @(negedge clk);
        check("midscan_rst_valid", v0, 0);
        check("midscan_rst_busy", busy0, 0);
        check("midscan_rst_count", cnt0, 0);
        next_cycle();
        rdy0 = 1'b1;
        repeat (10) next_cycle();
        @(negedge clk);
        check("midscan_quiet", v0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter NUM_NEURONS, default 32: width of the spike vector sampled from the neuron array.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two: number of event words buffered.
REQ-003 Parameter BASE_ADDR, default 10'd0: address offset added to each neuron index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 time_step  input  1  one-cycle pulse marking the end of a time step; spikes_in is sampled on it.
REQ-007 spikes_in  input  NUM_NEURONS  spike outputs of the neurons; bit i is neuron i.
REQ-008 out_valid  output  1  event word available at out_word.
REQ-009 out_ready  input  1  consumer accepts out_word.
REQ-010 out_word  output  32  [9:0] neuron address, [15:10] zero, [31:16] timestamp or zero (REQ-030/031).
REQ-011 busy  output  1  high while the encoder is scanning a snapshot.
REQ-012 overflow  output  1  sticky flag: a time step was dropped.
REQ-013 spike_count  output  16  total events pushed, saturating.

Function
REQ-014 FSM states: IDLE and SCAN; busy SHALL equal (state == SCAN).
REQ-015 IDLE, time_step=1, spikes_in!=0: load spikes_in into the snapshot register; next state SCAN.
REQ-016 IDLE, time_step=1, spikes_in==0: no snapshot load; stay IDLE; no event pushed.
REQ-017 SCAN, each cycle: select the lowest-index set snapshot bit i; if the FIFO is not full, push BASE_ADDR+i (truncated to 10 bits) and clear bit i.
REQ-018 SCAN with FIFO full: no push, snapshot unchanged (stall); events are never dropped.
REQ-019 SCAN: when the push clears the last set bit, next state SCAN->IDLE on that same edge.
REQ-020 time_step during SCAN: set overflow; discard the new vector; the scan in progress continues unaffected.
REQ-021 Throughput: one event per cycle when not stalled; an N-spike time step takes N SCAN cycles.
REQ-022 Latency: time_step at cycle t with an empty FIFO -> first event has out_valid=1 in cycle t+2.
REQ-023 FIFO: first-word-fall-through; out_word is valid whenever out_valid=1; pop occurs when out_valid && out_ready.
REQ-024 Simultaneous push and pop with the FIFO not full: both occur; the occupancy count is unchanged.
REQ-025 The full flag is registered; a pop in the same cycle does not enable a push into a full FIFO.
REQ-026 out_word SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Pointers wrap modulo FIFO_DEPTH; the count range is 0..FIFO_DEPTH.
REQ-028 spike_count increments by 1 per push; it holds at 16'hFFFF.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE, snapshot=0, FIFO empty (out_valid=0), out_word=0, busy=0, overflow=0, spike_count=0, timestamp=0; reset overrides time_step and out_ready, and a scan in progress is abandoned.

Configuration
REQ-030 SPIKE_TIMESTAMP_EN defined:
  - a 16-bit timestamp counter increments on every time_step (including dropped ones) and wraps 16'hFFFF->0;
  - each event carries, in out_word[31:16], the counter value present when its snapshot was taken (before the increment).
REQ-031 SPIKE_TIMESTAMP_EN undefined: no timestamp counter; out_word[31:16] SHALL be constant zero.

Verification
REQ-032 Reset, then time_step with spikes_in=32'h0000_0005, out_ready=1 -> out_word[9:0]=0 at cycle t+2, then 2 at t+3; busy high for 2 cycles; spike_count=2.
REQ-033 out_ready=0, time_step with spikes_in=32'hFFFF_FFFF, FIFO_DEPTH=16 -> 16 events buffered, busy stays 1 (stall); after out_ready=1, all 32 addresses 0..31 emerge in order; overflow=0.
REQ-034 Second time_step 3 cycles after a 32'h0000_00FF snapshot -> overflow=1; exactly 8 events (addresses 0..7) are output.
REQ-035 BASE_ADDR=10'd1000, spikes_in bit 30 set -> out_word[9:0]=10'd6 (wrap from 1030).
REQ-036 With SPIKE_TIMESTAMP_EN: three time_steps (spikes 0, bit3, bit3) -> events stamped 1 and 2; without the macro, out_word[31:16]=0.
REQ-037 Assert rst during SCAN with 4 bits pending -> next cycle out_valid=0, busy=0, spike_count=0; no further events.
